// File: rtl/canvas_write_scheduler.sv
// canvas_write_scheduler: sole write port into the layer canvases.
// Forwards tool pixels to the active layer and runs black-fill clear sweeps.
module canvas_write_scheduler #(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int LAYERS      = 4,
  parameter int COLOR_WIDTH = 4,
  parameter logic [COLOR_WIDTH-1:0] COLOR_BLACK = '0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      tool_valid,
  input  logic [$clog2(WIDTH)-1:0]  tool_x,
  input  logic [$clog2(HEIGHT)-1:0] tool_y,
  input  logic [COLOR_WIDTH-1:0]    tool_color,
  input  logic [2:0]                active_layer,
  input  logic [LAYERS-1:0]         layer_visible,
  input  logic                      clear_req,
  input  logic                      clear_all_req,
  output logic                      tool_ready,
  output logic                      busy,
  output logic                      clear_done,
  output logic [LAYERS-1:0]         wr_en,
  output logic [$clog2(WIDTH)-1:0]  wr_x,
  output logic [$clog2(HEIGHT)-1:0] wr_y,
  output logic [COLOR_WIDTH-1:0]    wr_color
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLEAR = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]        state;
  logic [LAYERS-1:0] mask;
  logic [XW-1:0]     cx;
  logic [YW-1:0]     cy;

  logic              layer_ok;
  logic [LAYERS-1:0] layer_oh;
  logic              in_range;
  logic              tool_go;
  logic              clr_go;
  logic              sweep_last;

  // Decode the active layer and qualify tool writes and clear requests.
  always_comb begin
    layer_ok   = (active_layer != 3'd0) &&
                 (32'(active_layer) <= LAYERS);
    layer_oh   = '0;
    if (layer_ok)
      layer_oh = LAYERS'(1) << (active_layer - 3'd1);
    in_range   = (32'(tool_x) < WIDTH) && (32'(tool_y) < HEIGHT);
    tool_go    = tool_valid && layer_ok && in_range &&
                 (|(layer_oh & layer_visible));
    clr_go     = clear_all_req || (clear_req && layer_ok);
    sweep_last = (cx == X_LAST) && (cy == Y_LAST);
  end

  // Sequencer: registered outputs describe the write issued on this edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      mask       <= '0;
      cx         <= '0;
      cy         <= '0;
      wr_en      <= '0;
      wr_x       <= '0;
      wr_y       <= '0;
      wr_color   <= COLOR_BLACK;
      busy       <= 1'b0;
      clear_done <= 1'b0;
      tool_ready <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          clear_done <= 1'b0;
          wr_en      <= tool_go ? layer_oh : '0;
          if (tool_go) begin
            wr_x     <= tool_x;
            wr_y     <= tool_y;
            wr_color <= tool_color;
          end
          cx <= '0;
          cy <= '0;
          if (clr_go) begin
            mask       <= clear_all_req ? '1 : layer_oh;
            state      <= CLEAR;
            busy       <= 1'b1;
            tool_ready <= 1'b0;
          end else begin
            busy       <= 1'b0;
            tool_ready <= 1'b1;
          end
        end
        CLEAR: begin
          wr_en      <= mask;
          wr_x       <= cx;
          wr_y       <= cy;
          wr_color   <= COLOR_BLACK;
          busy       <= 1'b1;
          tool_ready <= 1'b0;
          if (sweep_last) begin
            state <= DONE;
          end else if (cx == X_LAST) begin
            cx <= '0;
            cy <= cy + 1'b1;
          end else begin
            cx <= cx + 1'b1;
          end
        end
        DONE: begin
          wr_en      <= '0;
          clear_done <= 1'b1;
          busy       <= 1'b1;
          tool_ready <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          wr_en      <= '0;
          clear_done <= 1'b0;
          busy       <= 1'b0;
          tool_ready <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_canvas_write_scheduler.sv
// tb_canvas_write_scheduler: directed checks of tool writes,
// clear sweeps, interference, collision and reset abort.
module tb_canvas_write_scheduler;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tool_valid;
  logic [2:0] tool_x;
  logic [2:0] tool_y;
  logic [3:0] tool_color;
  logic [2:0] active_layer;
  logic [3:0] layer_visible;
  logic       clear_req;
  logic       clear_all_req;
  logic       tool_ready;
  logic       busy;
  logic       clear_done;
  logic [3:0] wr_en;
  logic [2:0] wr_x;
  logic [2:0] wr_y;
  logic [3:0] wr_color;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  canvas_write_scheduler #(
    .WIDTH(8), .HEIGHT(8), .LAYERS(4), .COLOR_WIDTH(4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .tool_valid(tool_valid), .tool_x(tool_x), .tool_y(tool_y),
    .tool_color(tool_color), .active_layer(active_layer),
    .layer_visible(layer_visible), .clear_req(clear_req),
    .clear_all_req(clear_all_req), .tool_ready(tool_ready),
    .busy(busy), .clear_done(clear_done), .wr_en(wr_en),
    .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    total++;
    if (wr_en !== 4'b0 || busy !== 1'b0 || clear_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_outs: wr_en=%b busy=%b done=%b want 0000 0 0",
               wr_en, busy, clear_done);
    end
    total++;
    if (tool_ready !== 1'b1 || wr_color !== 4'h0) begin
      bad++;
      $display("FAIL reset_ready: ready=%b color=%h want 1 0",
               tool_ready, wr_color);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_tool_write();
    active_layer = 3'd2; layer_visible = 4'b0010;
    tool_x = 3'd3; tool_y = 3'd5; tool_color = 4'hA; tool_valid = 1'b1;
    step();
    tool_valid = 1'b0;
    total++;
    if (wr_en !== 4'b0010 || wr_x !== 3'd3 || wr_y !== 3'd5 ||
        wr_color !== 4'hA) begin
      bad++;
      $display("FAIL tool_write: en=%b x=%0d y=%0d c=%h want 0010 3 5 a",
               wr_en, wr_x, wr_y, wr_color);
    end
    step();
    total++;
    if (wr_en !== 4'b0) begin
      bad++;
      $display("FAIL tool_one_cycle: en=%b want 0000", wr_en);
    end
  endtask

  task automatic test_reject();
    logic [2:0] lay [3] = '{3'd2, 3'd0, 3'd5};
    logic [3:0] vis [3] = '{4'b0000, 4'b1111, 4'b1111};
    for (int i = 0; i < 3; i++) begin
      active_layer = lay[i]; layer_visible = vis[i];
      tool_x = 3'd3; tool_y = 3'd5; tool_color = 4'h7; tool_valid = 1'b1;
      step();
      total++;
      if (wr_en !== 4'b0) begin
        bad++;
        $display("FAIL reject_%0d: en=%b want 0000", i, wr_en);
      end
    end
    tool_valid = 1'b0;
    step();
  endtask

  task automatic sweep_check(input string nm, input logic [3:0] m,
                             input int from);
    int errs = 0;
    for (int i = from; i < 64; i++) begin
      step();
      if (wr_en !== m || wr_x !== 3'(i % 8) || wr_y !== 3'(i / 8) ||
          wr_color !== 4'h0 || clear_done !== 1'b0 || busy !== 1'b1) begin
        if (errs == 0)
          $display("FAIL %s_px%0d: en=%b x=%0d y=%0d want %b %0d %0d",
                   nm, i, wr_en, wr_x, wr_y, m, i % 8, i / 8);
        errs++;
      end
    end
    total++;
    if (errs != 0) bad++;
    step();
    total++;
    if (clear_done !== 1'b1 || wr_en !== 4'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL %s_done: done=%b en=%b busy=%b want 1 0000 1",
               nm, clear_done, wr_en, busy);
    end
    step();
    total++;
    if (busy !== 1'b0 || clear_done !== 1'b0 || tool_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_idle: busy=%b done=%b ready=%b want 0 0 1",
               nm, busy, clear_done, tool_ready);
    end
  endtask

  task automatic test_single_clear();
    active_layer = 3'd3; layer_visible = 4'b0000; clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    total++;
    if (busy !== 1'b1 || tool_ready !== 1'b0 || wr_en !== 4'b0) begin
      bad++;
      $display("FAIL clr_arm: busy=%b ready=%b en=%b want 1 0 0000",
               busy, tool_ready, wr_en);
    end
    sweep_check("clr1", 4'b0100, 0);
  endtask

  task automatic test_clear_all_interference();
    int errs = 0;
    clear_all_req = 1'b1; active_layer = 3'd1;
    step();
    clear_all_req = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i == 5) begin
        tool_valid = 1'b1; layer_visible = 4'b1111; tool_color = 4'h9;
      end
      if (i == 6) begin tool_valid = 1'b0; clear_req = 1'b1; end
      if (i == 7) begin clear_req = 1'b0; active_layer = 3'd4; end
      if (i == 9) clear_all_req = 1'b1;
      if (i == 10) clear_all_req = 1'b0;
      step();
      if (wr_en !== 4'b1111 || wr_x !== 3'(i % 8) || wr_y !== 3'(i / 8) ||
          wr_color !== 4'h0) begin
        if (errs == 0)
          $display("FAIL clrall_px%0d: en=%b x=%0d y=%0d c=%h want 1111",
                   i, wr_en, wr_x, wr_y, wr_color);
        errs++;
      end
    end
    total++;
    if (errs != 0) bad++;
    step();
    total++;
    if (clear_done !== 1'b1 || wr_en !== 4'b0) begin
      bad++;
      $display("FAIL clrall_done: done=%b en=%b want 1 0000",
               clear_done, wr_en);
    end
    step();
    step();
    total++;
    if (busy !== 1'b0 || wr_en !== 4'b0) begin
      bad++;
      $display("FAIL clrall_no_resweep: busy=%b en=%b want 0 0000",
               busy, wr_en);
    end
  endtask

  task automatic test_collision();
    active_layer = 3'd1; layer_visible = 4'b0001;
    tool_x = 3'd2; tool_y = 3'd1; tool_color = 4'h5;
    tool_valid = 1'b1; clear_req = 1'b1;
    step();
    tool_valid = 1'b0; clear_req = 1'b0;
    total++;
    if (wr_en !== 4'b0001 || wr_x !== 3'd2 || wr_y !== 3'd1 ||
        wr_color !== 4'h5 || busy !== 1'b1) begin
      bad++;
      $display("FAIL coll_tool: en=%b x=%0d y=%0d c=%h busy=%b want 0001 2 1 5 1",
               wr_en, wr_x, wr_y, wr_color, busy);
    end
    sweep_check("coll", 4'b0001, 0);
  endtask

  task automatic test_abort();
    int errs = 0;
    active_layer = 3'd2; clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    for (int i = 0; i <= 20; i++) step();
    total++;
    if (wr_en !== 4'b0010 || wr_x !== 3'd4 || wr_y !== 3'd2) begin
      bad++;
      $display("FAIL abort_px20: en=%b x=%0d y=%0d want 0010 4 2",
               wr_en, wr_x, wr_y);
    end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    total++;
    if (wr_en !== 4'b0 || busy !== 1'b0 || clear_done !== 1'b0 ||
        tool_ready !== 1'b1) begin
      bad++;
      $display("FAIL abort_rst: en=%b busy=%b done=%b ready=%b want 0 0 0 1",
               wr_en, busy, clear_done, tool_ready);
    end
    for (int i = 0; i < 70; i++) begin
      step();
      if (clear_done !== 1'b0 || wr_en !== 4'b0 || busy !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL abort_quiet: %0d active cycles want 0", errs);
    end
    layer_visible = 4'b0010; tool_x = 3'd7; tool_y = 3'd7;
    tool_color = 4'hF; tool_valid = 1'b1;
    step();
    tool_valid = 1'b0;
    total++;
    if (wr_en !== 4'b0010 || wr_x !== 3'd7 || wr_y !== 3'd7) begin
      bad++;
      $display("FAIL abort_idle_write: en=%b x=%0d y=%0d want 0010 7 7",
               wr_en, wr_x, wr_y);
    end
  endtask

  initial begin
    reset_n = 1'b0; tool_valid = 1'b0; tool_x = '0; tool_y = '0;
    tool_color = '0; active_layer = '0; layer_visible = '0;
    clear_req = 1'b0; clear_all_req = 1'b0;
    test_reset();
    test_tool_write();
    test_reject();
    test_single_clear();
    test_clear_all_interference();
    test_collision();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
